// File: rtl/xpb_table_gen.sv
// Builds the k*B mod M reduction table (B = 2^SHIFT mod M) for the xpb lookup blocks.
// The base is found by SHIFT modular doublings; entries are then streamed by modular accumulation.
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int SEL_BITS = 5,
  parameter int SHIFT    = 700
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                wr_en,
  output logic [SEL_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data
);

  localparam int CNT_W = $clog2(SHIFT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SHIFT - 1);
  localparam logic [SEL_BITS-1:0] K_LAST   = {SEL_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOUBLE = 2'd1,
    TABLE  = 2'd2,
    FIN    = 2'd3
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    m_q;
  logic [WIDTH-1:0]    r_q;
  logic [WIDTH-1:0]    base_q;
  logic [WIDTH-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SEL_BITS-1:0] k_q;
  logic [WIDTH-1:0]    r_d;
  logic [WIDTH-1:0]    acc_d;

  // Operands are already below m, so a single conditional subtract brings t back into range.
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] t,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] diff;
    m_ext = {1'b0, m};
    diff  = t - m_ext;
    if (t >= m_ext) begin
      return diff[WIDTH-1:0];
    end else begin
      return t[WIDTH-1:0];
    end
  endfunction

  // Next doubling and next accumulated entry, both reduced modulo the captured modulus.
  always_comb begin
    r_d   = mod_reduce({r_q, 1'b0}, m_q);
    acc_d = mod_reduce({1'b0, acc_q} + {1'b0, base_q}, m_q);
  end

  // Build sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      r_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (start) begin
            m_q     <= modulus;
            r_q     <= WIDTH'(1);
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= DOUBLE;
          end
        end
        DOUBLE: begin
          r_q   <= r_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // The final doubling feeds the base directly, saving a separate latch cycle.
          if (cnt_q == CNT_LAST) begin
            base_q  <= r_d;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= TABLE;
          end
        end
        TABLE: begin
          wr_en   <= 1'b1;
          wr_addr <= k_q;
          wr_data <= acc_q;
          acc_q   <= acc_d;
          k_q     <= k_q + SEL_BITS'(1);
          if (k_q == K_LAST) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          wr_en   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          wr_en   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: three configurations, expected table entries queued at start and
// popped as writes appear, with busy/done/write-window timing checked cycle by cycle.
module tb_xpb_table_gen;

  logic clk;
  logic rst_n;

  // A: WIDTH=16, SEL_BITS=2, SHIFT=4
  logic        a_start, a_busy, a_done, a_wr_en;
  logic [15:0] a_mod, a_wr_data;
  logic [1:0]  a_wr_addr;
  // B: WIDTH=16, SEL_BITS=3, SHIFT=4
  logic        b_start, b_busy, b_done, b_wr_en;
  logic [15:0] b_mod, b_wr_data;
  logic [2:0]  b_wr_addr;
  // C: default parameters
  logic          c_start, c_busy, c_done, c_wr_en;
  logic [1023:0] c_mod, c_wr_data;
  logic [4:0]    c_wr_addr;

  int errors = 0;
  int checks = 0;
  int            exp_addr_q[$];
  logic [1023:0] exp_data_q[$];

  xpb_table_gen #(.WIDTH(16), .SEL_BITS(2), .SHIFT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .modulus(a_mod), .busy(a_busy),
    .done(a_done), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data));
  xpb_table_gen #(.WIDTH(16), .SEL_BITS(3), .SHIFT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .modulus(b_mod), .busy(b_busy),
    .done(b_done), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));
  xpb_table_gen u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .modulus(c_mod), .busy(c_busy),
    .done(c_done), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_mod = 16'd0; b_mod = 16'd0; c_mod = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_wr_en, a_wr_addr, a_wr_data} !== 21'd0) begin
      errors++; $display("FAIL reset_a: got busy=%b done=%b wr_en=%b addr=%0d data=%h, expected all 0",
                         a_busy, a_done, a_wr_en, a_wr_addr, a_wr_data);
    end
    checks++;
    if ({b_busy, b_done, b_wr_en, b_wr_addr, b_wr_data} !== 22'd0) begin
      errors++; $display("FAIL reset_b: got busy=%b done=%b wr_en=%b addr=%0d, expected all 0",
                         b_busy, b_done, b_wr_en, b_wr_addr);
    end
    checks++;
    if (c_busy !== 1'b0 || c_done !== 1'b0 || c_wr_en !== 1'b0 || c_wr_addr !== 5'd0 ||
        c_wr_data !== 1024'd0) begin
      errors++; $display("FAIL reset_c: got busy=%b done=%b wr_en=%b addr=%0d, expected all 0",
                         c_busy, c_done, c_wr_en, c_wr_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Basic build on A with M=13; mod_after is driven onto modulus once the start is captured.
  task automatic test_m13(input logic [15:0] mod_after);
    logic [1023:0] d;
    int ea;
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back(1024'(3 * k));
    end
    a_mod = 16'd13; a_start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      a_start = 1'b0; a_mod = mod_after;
      checks++;
      if (a_busy !== (i <= 9)) begin
        errors++; $display("FAIL m13_busy: cycle %0d got %b expected %b", i, a_busy, (i <= 9));
      end
      checks++;
      if (a_done !== (i == 10)) begin
        errors++; $display("FAIL m13_done: cycle %0d got %b expected %b", i, a_done, (i == 10));
      end
      checks++;
      if (a_wr_en !== (i >= 6 && i <= 9)) begin
        errors++; $display("FAIL m13_wr_en: cycle %0d got %b expected %b", i, a_wr_en, (i >= 6 && i <= 9));
      end
      if (a_wr_en === 1'b1 && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front(); d = exp_data_q.pop_front();
        checks++;
        if (a_wr_addr !== ea[1:0] || a_wr_data !== d[15:0]) begin
          errors++; $display("FAIL m13_entry: got (%0d,%0d) expected (%0d,%0d)",
                             a_wr_addr, a_wr_data, ea, d[15:0]);
        end
      end
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL m13_count: %0d entries missing, expected 0", exp_addr_q.size());
      exp_addr_q.delete(); exp_data_q.delete();
    end
  endtask

  task automatic test_m7_wrap();
    logic [1023:0] d;
    int ea;
    int exp_tab[8] = '{0, 2, 4, 6, 1, 3, 5, 0};
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back(1024'(exp_tab[k]));
    end
    b_mod = 16'd7; b_start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      b_start = 1'b0;
      checks++;
      if (b_busy !== (i <= 13) || b_done !== (i == 14) || b_wr_en !== (i >= 6 && i <= 13)) begin
        errors++; $display("FAIL m7_timing: cycle %0d got busy=%b done=%b wr_en=%b", i, b_busy, b_done, b_wr_en);
      end
      if (b_wr_en === 1'b1 && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front(); d = exp_data_q.pop_front();
        checks++;
        if (b_wr_addr !== ea[2:0] || b_wr_data !== d[15:0]) begin
          errors++; $display("FAIL m7_entry: got (%0d,%0d) expected (%0d,%0d)",
                             b_wr_addr, b_wr_data, ea, d[15:0]);
        end
      end
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL m7_count: %0d entries missing, expected 0", exp_addr_q.size());
      exp_addr_q.delete(); exp_data_q.delete();
    end
  endtask

  task automatic test_default_full();
    logic [1023:0] d;
    int ea;
    int done_at;
    done_at = 0;
    for (int k = 0; k < 32; k++) begin
      d = 1024'(k);
      exp_addr_q.push_back(k);
      exp_data_q.push_back(d << 700);
    end
    c_mod = '1; c_start = 1'b1;
    for (int i = 1; i <= 740; i++) begin
      @(negedge clk);
      c_start = 1'b0;
      if (c_done === 1'b1 && done_at == 0) done_at = i;
      checks++;
      if (c_busy !== (i <= 733) || c_done !== (i == 734) || c_wr_en !== (i >= 702 && i <= 733)) begin
        errors++; $display("FAIL dflt_timing: cycle %0d got busy=%b done=%b wr_en=%b", i, c_busy, c_done, c_wr_en);
      end
      if (c_wr_en === 1'b1 && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front(); d = exp_data_q.pop_front();
        checks++;
        if (c_wr_addr !== ea[4:0] || c_wr_data !== d) begin
          errors++; $display("FAIL dflt_entry: addr got %0d expected %0d, data high word got %h expected %h",
                             c_wr_addr, ea, c_wr_data[767:640], d[767:640]);
        end
      end
    end
    checks++;
    if (done_at != 734) begin
      errors++; $display("FAIL dflt_latency: got %0d expected 734", done_at);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL dflt_count: %0d entries missing, expected 0", exp_addr_q.size());
      exp_addr_q.delete(); exp_data_q.delete();
    end
  endtask

  task automatic test_start_ignored();
    logic [1023:0] d;
    int ea;
    int done_cnt;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back(1024'(3 * k));
    end
    a_mod = 16'd13; a_start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      a_start = (i == 2 || i == 3 || i == 7 || i == 8);
      a_mod = (i == 2 || i == 3) ? 16'd7 : ((i == 7 || i == 8) ? 16'd5 : 16'd13);
      if (a_done === 1'b1) done_cnt++;
      checks++;
      if (a_busy !== (i <= 9) || a_done !== (i == 10) || a_wr_en !== (i >= 6 && i <= 9)) begin
        errors++; $display("FAIL ign_timing: cycle %0d got busy=%b done=%b wr_en=%b", i, a_busy, a_done, a_wr_en);
      end
      if (a_wr_en === 1'b1 && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front(); d = exp_data_q.pop_front();
        checks++;
        if (a_wr_addr !== ea[1:0] || a_wr_data !== d[15:0]) begin
          errors++; $display("FAIL ign_entry: got (%0d,%0d) expected (%0d,%0d)",
                             a_wr_addr, a_wr_data, ea, d[15:0]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL ign_count: %0d entries missing, expected 0", exp_addr_q.size());
      exp_addr_q.delete(); exp_data_q.delete();
    end
  endtask

  task automatic test_reset_mid_table();
    logic [1023:0] d;
    int ea;
    for (int k = 0; k < 2; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back(1024'(3 * k));
    end
    a_mod = 16'd13; a_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      rst_n = (i != 7);
      if (i <= 7) begin
        checks++;
        if (a_busy !== 1'b1 || a_done !== 1'b0 || a_wr_en !== (i >= 6)) begin
          errors++; $display("FAIL rst_pre: cycle %0d got busy=%b done=%b wr_en=%b", i, a_busy, a_done, a_wr_en);
        end
        if (a_wr_en === 1'b1 && exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front(); d = exp_data_q.pop_front();
          checks++;
          if (a_wr_addr !== ea[1:0] || a_wr_data !== d[15:0]) begin
            errors++; $display("FAIL rst_entry: got (%0d,%0d) expected (%0d,%0d)",
                               a_wr_addr, a_wr_data, ea, d[15:0]);
          end
        end
      end else begin
        checks++;
        if ({a_busy, a_done, a_wr_en, a_wr_addr, a_wr_data} !== 21'd0) begin
          errors++; $display("FAIL rst_post: cycle %0d got busy=%b done=%b wr_en=%b addr=%0d data=%0d expected all 0",
                             i, a_busy, a_done, a_wr_en, a_wr_addr, a_wr_data);
        end
      end
    end
    rst_n = 1'b1;
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL rst_count: %0d entries missing, expected 0", exp_addr_q.size());
      exp_addr_q.delete(); exp_data_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] d;
    int ea;
    int exp_tab[8] = '{0, 3, 6, 9, 0, 2, 4, 6};
    logic eb, ed, ew;
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(k % 4);
      exp_data_q.push_back(1024'(exp_tab[k]));
    end
    a_mod = 16'd13; a_start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      eb = (i <= 9) || (i >= 11 && i <= 19);
      ed = (i == 10) || (i == 20);
      ew = (i >= 6 && i <= 9) || (i >= 16 && i <= 19);
      checks++;
      if (a_busy !== eb || a_done !== ed || a_wr_en !== ew) begin
        errors++; $display("FAIL b2b_timing: cycle %0d got busy=%b done=%b wr_en=%b expected %b %b %b",
                           i, a_busy, a_done, a_wr_en, eb, ed, ew);
      end
      if (a_wr_en === 1'b1 && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front(); d = exp_data_q.pop_front();
        checks++;
        if (a_wr_addr !== ea[1:0] || a_wr_data !== d[15:0]) begin
          errors++; $display("FAIL b2b_entry: got (%0d,%0d) expected (%0d,%0d)",
                             a_wr_addr, a_wr_data, ea, d[15:0]);
        end
      end
      // Second request is presented as soon as the first done is observed.
      a_start = (a_done === 1'b1 && i < 15);
      if (a_done === 1'b1 && i < 15) a_mod = 16'd7;
    end
    a_start = 1'b0;
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: %0d entries missing, expected 0", exp_addr_q.size());
      exp_addr_q.delete(); exp_data_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_m13(16'd0);
    test_m7_wrap();
    test_default_full();
    test_start_ignored();
    test_reset_mid_table();
    test_m13(16'd11);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
